// File: rtl/serial_adder.sv
// Digit-serial W-bit adder: D bits per clock, carry held between steps, valid/ready on both sides.
// Optional subtraction is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (W < 2 || (W % D) != 0) begin : g_bad_cfg
      $error("serial_adder: W must be >= 2 and a multiple of D");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, s_reg;
  logic [W-1:0]    a_shift, b_shift, s_next;
  logic            carry_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    sum_reg;
  logic            c_out_reg, ovf_reg;
  logic [D-1:0]    a_dig, b_dig, dig_sum;
  logic            dig_carry, msb_carry_in;
  logic            accept, last_step, sub_eff;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  logic sub_unused;
  assign sub_unused = sub;
  assign sub_eff    = 1'b0;
`endif

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_reg == CW'(N - 1));

  // Operands shift right one digit per step, so the active digit is always the low one.
  assign a_dig = a_reg[D-1:0];
  assign b_dig = b_reg[D-1:0];
  assign {dig_carry, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_reg};
  // On the last step the digit's MSB is bit W-1; its incoming carry is a^b^s there.
  assign msb_carry_in = a_dig[D-1] ^ b_dig[D-1] ^ dig_sum[D-1];

  generate
    if (N == 1) begin : g_single
      assign a_shift = a_reg;
      assign b_shift = b_reg;
      assign s_next  = dig_sum;
    end else begin : g_multi
      assign a_shift = {{D{1'b0}}, a_reg[W-1:D]};
      assign b_shift = {{D{1'b0}}, b_reg[W-1:D]};
      assign s_next  = {dig_sum, s_reg[W-1:D]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= sub_eff ? ~b : b;
      carry_reg <= sub_eff ? 1'b1 : c_in;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      a_reg     <= a_shift;
      b_reg     <= b_shift;
      s_reg     <= s_next;
      carry_reg <= dig_carry;
      cnt_reg   <= cnt_reg + CW'(1);
      if (last_step) begin
        sum_reg   <= s_next;
        c_out_reg <= dig_carry;
        ovf_reg   <= dig_carry ^ msb_carry_in;
      end
    end
  end

  assign sum   = sum_reg;
  assign c_out = c_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes model results, a monitor pops on each new result.
// Model follows SERIAL_ADDER_SUB_EN the same way the build does.
module tb_serial_adder;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0, sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out, ovf;

  always #5 clk = ~clk;

  serial_adder #(.W(W), .D(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    int           acc_cyc;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic sb);
    exp_t   e;
    longint m, ua, ub, tot, sa, sbv, st;
    bit     s;
`ifdef SERIAL_ADDER_SUB_EN
    s = sb;
`else
    s = 1'b0;
`endif
    m   = longint'(1) << W;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      tot = ua + (m - ub);
      st  = sa - sbv;
    end else begin
      tot = ua + ub + longint'(ci);
      st  = sa + sbv + longint'(ci);
    end
    e.sum     = W'(tot % m);
    e.c_out   = (tot >= m);
    e.ovf     = (st < -(m / 2)) || (st >= m / 2);
    e.acc_cyc = 0;
    e.a       = av;
    e.b       = bv;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    exp_t e;
    int   t = 0;
    @(posedge clk); #1;
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    e         = model(av, bv, ci, sb);
    e.acc_cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", sb_q.size(), 0);
  endtask

  // Monitor: compare on each rising out_valid, then check the result holds while stalled.
  logic         prev_valid = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_c, held_o;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_result", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          $display("txn a=%04h b=%04h -> sum=%04h c_out=%0b ovf=%0b (exp %04h %0b %0b)",
                   e.a, e.b, sum, c_out, ovf, e.sum, e.c_out, e.ovf);
          check("latency", cyc - e.acc_cyc, N);
          check("sum", sum, e.sum);
          check("c_out", c_out, e.c_out);
          check("ovf", ovf, e.ovf);
        end
        held_sum = sum;
        held_c   = c_out;
        held_o   = ovf;
      end else if (out_valid) begin
        check("hold_sum", sum, held_sum);
        check("hold_c_out", c_out, held_c);
        check("hold_ovf", ovf, held_o);
        check("in_ready_in_done", in_ready, 0);
      end
      prev_valid = out_valid;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    // Directed vectors, including carry/overflow boundaries and subtraction cases
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0000, 1'b1, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // Backpressure: result must hold while the next operands wait
    out_ready = 1'b0;
    send(16'hABCD, 16'h1111, 1'b1, 1'b0);
    fork
      send(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
      begin
        t = 0;
        while (!out_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("bp_valid_seen", out_valid, 1);
        repeat (5) @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset during the second RUN cycle discards the operation
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_sum", sum, 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0003, 16'h0004, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
